// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the 8:1 mux round-robin arbiter.
// Imported by the arbiter top, its picker and its interface.
package mux8_rr_arbiter_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_e;
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/data bundle between the requesters and the arbiter.
// The master side drives req and i; the slave side answers.
interface mux8_rr_arbiter_if;
  import mux8_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] i;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   s;
  logic               busy;
  logic               o;
  logic               o_vld;

  modport master (
    output req, i,
    input  gnt, s, busy, o, o_vld
  );

  modport slave (
    input  req, i,
    output gnt, s, busy, o, o_vld
  );
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted req after last,
// wrapping modulo NUM_REQ, with last itself scanned at the end.
module rr_pick
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner sequencer for the shared 8:1 mux, with a
// one-cycle break-before-make gap and a bounded hold time.
module mux8_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux8_rr_arbiter_if.slave  bus
);
  import mux8_rr_arbiter_pkg::*;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               o_q, o_d;
  logic               o_vld_q, o_vld_d;

  logic [SEL_W-1:0]   pick;
  logic               any;
  logic               others;
  logic               hold_hit;

  rr_pick u_pick (
    .req  (bus.req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign others   = |(bus.req & ~gnt_q);
  assign hold_hit = hold_q >= HOLD_W'(MAX_HOLD);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    o_d     = o_q;
    o_vld_d = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (any) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(1) << pick;
          s_d     = pick;
          last_d  = pick;
          hold_d  = HOLD_W'(1);
          busy_d  = 1'b1;
        end else if (state_q == GAP) begin
          state_d = IDLE;
        end
      end
      OWN: begin
        o_d     = bus.i[s_q];
        o_vld_d = 1'b1;
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        // s is left alone on release so the mux input stays put
        if (!bus.req[s_q] || (hold_hit && others)) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
      o_q     <= 1'b0;
      o_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      o_q     <= o_d;
      o_vld_q <= o_vld_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.busy  = busy_q;
  assign bus.o     = o_q;
  assign bus.o_vld = o_vld_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a cycle model predicts
// each edge's outputs, queued at drive time, compared after.
module tb_mux8_rr_arbiter;
  import mux8_rr_arbiter_pkg::*;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(
    .NUM_REQ  (8),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       o;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         m_st;
  logic [7:0] m_gnt;
  logic [2:0] m_s;
  logic [2:0] m_last;
  logic       m_busy;
  logic       m_o;
  logic       m_vld;
  int         m_hold;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] mpick(input logic [7:0] r,
                                       input logic [2:0] l);
    int idx;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(l) + k) % 8;
      if (r[idx]) return 3'(idx);
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_st   = 0;
    m_gnt  = 8'h00;
    m_s    = 3'd0;
    m_last = 3'd7;
    m_busy = 1'b0;
    m_o    = 1'b0;
    m_vld  = 1'b0;
    m_hold = 0;
  endtask

  task automatic model_step();
    logic [7:0] r;
    logic [7:0] d;
    logic [2:0] p;
    bit         grab;
    r     = bus.req;
    d     = bus.i;
    grab  = 1'b0;
    m_vld = 1'b0;
    case (m_st)
      0: grab = (r != 8'h00);
      1: begin
        m_o   = d[m_s];
        m_vld = 1'b1;
        if (!r[m_s] || (m_hold >= MAXH && (r & ~m_gnt) != 8'h00)) begin
          m_st   = 2;
          m_gnt  = 8'h00;
          m_busy = 1'b0;
        end
        if (m_hold < 255) m_hold++;
      end
      default: begin
        if (r != 8'h00) grab = 1'b1;
        else m_st = 0;
      end
    endcase
    if (grab) begin
      p      = mpick(r, m_last);
      m_st   = 1;
      m_gnt  = 8'h01 << p;
      m_s    = p;
      m_last = p;
      m_busy = 1'b1;
      m_hold = 1;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e = '{gnt: m_gnt, s: m_s, busy: m_busy, o: m_o, vld: m_vld};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", bus.gnt, e.gnt);
    check("s", bus.s, e.s);
    check("busy", bus.busy, e.busy);
    check("o", bus.o, e.o);
    check("o_vld", bus.o_vld, e.vld);
    check("onehot", $onehot0(bus.gnt), 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 8'h00;
    bus.i   = 8'h00;
    model_reset();
    sb.delete();
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_s", bus.s, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_vld", bus.o_vld, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int         ord[$];
    logic [7:0] prev;
    int         n;

    bus.req = 8'h00;
    bus.i   = 8'h00;
    do_reset();

    // idle after reset
    repeat (10) step();

    // single request from requester 3
    bus.i   = 8'h08;
    bus.req = 8'h08;
    step();
    check("single_gnt", bus.gnt, 8'h08);
    check("single_s", bus.s, 3);
    check("single_busy", bus.busy, 1);
    step();
    check("single_o", bus.o, 1);
    step();
    bus.req = 8'h00;
    step();
    check("single_gap", bus.gnt, 0);
    check("single_lastvld", bus.o_vld, 1);
    step();
    check("single_idle", bus.o_vld, 0);
    step();

    // fairness: everyone requests, owner drops after 2 cycles
    do_reset();
    bus.i = 8'hA5;
    prev  = 8'h00;
    for (int c = 0; c < 40 && ord.size() < 9; c++) begin
      bus.req = 8'hFF;
      if (m_st == 1 && m_hold == 2) bus.req[m_s] = 1'b0;
      step();
      if (prev == 8'h00 && bus.gnt != 8'h00) ord.push_back(int'(bus.s));
      prev = bus.gnt;
    end
    check("rr_count", ord.size(), 9);
    foreach (ord[k]) check("rr_order", ord[k], k % 8);

    // preemption at the hold limit
    do_reset();
    bus.i   = 8'h24;
    bus.req = 8'h04;
    step();
    bus.req = 8'h24;
    step();
    step();
    step();
    check("pre_own4", bus.gnt, 8'h04);
    step();
    check("pre_gap", bus.gnt, 0);
    step();
    check("pre_new", bus.gnt, 8'h20);
    step();
    bus.req = 8'h04;
    step();
    check("pre_gap2", bus.gnt, 0);
    step();
    check("pre_back", bus.gnt, 8'h04);
    bus.req = 8'h00;
    step();
    step();

    // lone requester never preempted
    do_reset();
    bus.req = 8'h40;
    n = 0;
    repeat (20) begin
      step();
      if (bus.gnt == 8'h40) n++;
    end
    check("alone_cnt", n, 20);
    bus.req = 8'h00;
    step();
    step();

    // asynchronous reset while requester 4 owns
    do_reset();
    bus.i   = 8'h10;
    bus.req = 8'h10;
    step();
    step();
    check("ar_own", bus.gnt, 8'h10);
    #2 rst = 1'b1;
    #1;
    check("ar_gnt", bus.gnt, 0);
    check("ar_s", bus.s, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_vld", bus.o_vld, 0);
    bus.req = 8'h11;
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("ar_first", bus.gnt, 8'h01);

    // random traffic against the model
    for (int c = 0; c < 200; c++) begin
      bus.req = 8'($urandom_range(0, 255));
      bus.i   = 8'($urandom_range(0, 255));
      if (c % 7 == 0) bus.req = 8'h00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
